fetch_sequencer: RTL

Control sequencer on the far side of the instruction fetch stage: it consumes the fetched instruction word and drives the fetch unit's run, halt, PC-reset and branch/jump controls. It starts a program from START_ADDRESS and resolves BR (relative, conditional) and JMP (absolute) redirects. It squashes the shadow instruction with a valid flag and stops on HALT. It sits between the fetch unit and decode, and all of its control outputs are registered.

---
 rtl/fetch_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Sequences the fetch unit: PC reset, fill, run, BR/JMP redirect with shadow squash, HALT.
// All controls are registered; a taken BR/JMP costs two invalid cycles, a not-taken BR none.
module fetch_sequencer #(
  parameter int INSN_WIDTH  = 9,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   _CLK,
  input  logic                   _reset,
  input  logic                   _start,
  input  logic [INSN_WIDTH-1:0]  _instruction,
  input  logic                   _condition,
  input  logic [DATA_WIDTH-1:0]  _jumpTarget,
  output logic                   run,
  output logic                   halt,
  output logic                   pcReset,
  output logic                   branchJump,
  output logic                   relative,
  output logic [DATA_WIDTH-1:0]  destBranchJump,
  output logic                   insnValid,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] insnCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PCRESET,
    S_FILL,
    S_RUN,
    S_REDIRECT,
    S_HALTED
  } state_t;

  localparam logic [2:0] OP_HALT = 3'b111;
  localparam logic [2:0] OP_BR   = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b101;

  state_t                state;
  logic [2:0]            opcode;
  logic [DATA_WIDTH-1:0] br_dest;

  assign opcode = _instruction[INSN_WIDTH-1 -: 3];
  // Fetch PC is already at branch+2 when the redirect lands, hence the -2.
  assign br_dest = {{(DATA_WIDTH-6){_instruction[5]}}, _instruction[5:0]} - DATA_WIDTH'(2);

  always_ff @(posedge _CLK or posedge _reset) begin
    if (_reset) begin
      state          <= S_IDLE;
      run            <= 1'b0;
      halt           <= 1'b0;
      pcReset        <= 1'b0;
      branchJump     <= 1'b0;
      relative       <= 1'b0;
      destBranchJump <= '0;
      insnValid      <= 1'b0;
      halted         <= 1'b0;
      insnCount      <= '0;
    end else begin
      if (insnValid)
        insnCount <= insnCount + COUNT_WIDTH'(1);

      case (state)
        S_IDLE: begin
          if (_start) begin
            state     <= S_PCRESET;
            pcReset   <= 1'b1;
            insnCount <= '0;
          end
        end
        S_PCRESET: begin
          state   <= S_FILL;
          pcReset <= 1'b0;
          run     <= 1'b1;
        end
        S_FILL: begin
          state     <= S_RUN;
          insnValid <= 1'b1;
        end
        S_RUN: begin
          case (opcode)
            OP_HALT: begin
              state     <= S_HALTED;
              run       <= 1'b0;
              halt      <= 1'b1;
              halted    <= 1'b1;
              insnValid <= 1'b0;
            end
            OP_BR: begin
              if (_condition) begin
                state          <= S_REDIRECT;
                run            <= 1'b0;
                insnValid      <= 1'b0;
                branchJump     <= 1'b1;
                relative       <= 1'b1;
                destBranchJump <= br_dest;
              end
            end
            OP_JMP: begin
              state          <= S_REDIRECT;
              run            <= 1'b0;
              insnValid      <= 1'b0;
              branchJump     <= 1'b1;
              relative       <= 1'b0;
              destBranchJump <= _jumpTarget;
            end
            default: ;
          endcase
        end
        S_REDIRECT: begin
          state          <= S_FILL;
          run            <= 1'b1;
          branchJump     <= 1'b0;
          relative       <= 1'b0;
          destBranchJump <= '0;
        end
        S_HALTED: begin
          if (_start) begin
            state     <= S_PCRESET;
            halt      <= 1'b0;
            halted    <= 1'b0;
            pcReset   <= 1'b1;
            insnCount <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
